// File: rtl/vedic_mul8_seq.sv
// 8x8 -> 16-bit multiply sequencer that time-shares one combinational 4x4 multiplier over four steps.
// Optional feature macro: VEDIC_SEQ_SIGNED_EN adds in_signed for two's-complement operands.
module vedic_mul8_seq #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [TAG_W-1:0] in_tag,
`ifdef VEDIC_SEQ_SIGNED_EN
  input  logic             in_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_p
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [15:0]      acc_q, acc_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             neg_q, neg_d;
  logic [15:0]      out_p_q, out_p_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic [7:0]       a_mag, b_mag;
  logic             neg_in;
  logic [15:0]      pp_shifted;

  // Magnitudes fed to the unsigned sequence; -128 maps to 0x80 naturally.
`ifdef VEDIC_SEQ_SIGNED_EN
  always_comb begin
    a_mag  = (in_signed && in_a[7]) ? 8'(~in_a + 8'd1) : in_a;
    b_mag  = (in_signed && in_b[7]) ? 8'(~in_b + 8'd1) : in_b;
    neg_in = in_signed && (in_a[7] ^ in_b[7]);
  end
`else
  always_comb begin
    a_mag  = in_a;
    b_mag  = in_b;
    neg_in = 1'b0;
  end
`endif

  always_comb begin
    pp_shifted = 16'd0;
    case (step_q)
      2'd0:    pp_shifted = {8'd0, mul_p};
      2'd1,
      2'd2:    pp_shifted = {4'd0, mul_p, 4'd0};
      default: pp_shifted = {mul_p, 8'd0};
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= 2'd0;
      acc_q     <= 16'd0;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      tag_q     <= '0;
      neg_q     <= 1'b0;
      out_p_q   <= 16'd0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      tag_q     <= tag_d;
      neg_q     <= neg_d;
      out_p_q   <= out_p_d;
      out_tag_q <= out_tag_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    tag_d     = tag_q;
    neg_d     = neg_q;
    out_p_d   = out_p_q;
    out_tag_d = out_tag_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_mag;
          b_d     = b_mag;
          tag_d   = in_tag;
          neg_d   = neg_in;
          acc_d   = 16'd0;
          step_d  = 2'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_q + pp_shifted;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          out_p_d   = neg_q ? 16'(~acc_d + 16'd1) : acc_d;
          out_tag_d = tag_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; the shared array sees zeros outside MUL so it stays quiet.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_p     = out_p_q;
    out_tag   = out_tag_q;
    mul_a     = 4'd0;
    mul_b     = 4'd0;
    if (state_q == MUL) begin
      mul_a = step_q[0] ? a_q[7:4] : a_q[3:0];
      mul_b = step_q[1] ? b_q[7:4] : b_q[3:0];
    end
  end

endmodule
